mdu_ctrl: RTL

Multi-cycle multiply/divide controller owning the HI/LO register pair, sitting beside the ALU in the EX stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse, holds `busy` high for a fixed latency per operation class, and commits results to HI/LO when the operation completes. Hazard logic uses `busy` and `start` to stall dependent multiply/divide instructions, and MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mdu_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO. Results are computed when the command is
// accepted, held in shadow registers, and committed after a fixed per-class latency.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } mdu_op_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_shHi;
   logic [31:0]   r_shLo;

   mdu_op_t       w_op;
   logic          w_isArith;
   logic          w_isMult;
   logic          w_divZero;
   logic          w_divOvf;
   logic [31:0]   w_divisorS;
   logic [31:0]   w_divisorU;
   logic [63:0]   w_prodS;
   logic [63:0]   w_prodU;
   logic [31:0]   w_quotS;
   logic [31:0]   w_remS;
   logic [31:0]   w_quotU;
   logic [31:0]   w_remU;
   logic [63:0]   w_result;
   logic [CW-1:0] w_latency;

   assign w_op      = mdu_op_t'(mdu_op);
   assign w_isArith = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                      (w_op == OP_DIV)  || (w_op == OP_DIVU);
   assign w_isMult  = (w_op == OP_MULT) || (w_op == OP_MULTU);
   assign w_latency = w_isMult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

   assign w_prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_prodU = {32'd0, A} * {32'd0, B};

   // Zero and overflow divisors are swapped for 1 so the dividers never see an
   // undefined case; those results are overridden below anyway.
   assign w_divZero  = (B == 32'd0);
   assign w_divOvf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign w_divisorS = (w_divZero || w_divOvf) ? 32'd1 : B;
   assign w_divisorU = w_divZero ? 32'd1 : B;

   assign w_quotS = $signed(A) / $signed(w_divisorS);
   assign w_remS  = $signed(A) % $signed(w_divisorS);
   assign w_quotU = A / w_divisorU;
   assign w_remU  = A % w_divisorU;

   always_comb begin
      w_result = {r_hi, r_lo};
      case (w_op)
         OP_MULT:  w_result = w_prodS;
         OP_MULTU: w_result = w_prodU;
         OP_DIV: begin
            if (w_divZero)
               w_result = {r_hi, r_lo};
            else if (w_divOvf)
               w_result = {32'd0, 32'h8000_0000};
            else
               w_result = {w_remS, w_quotS};
         end
         OP_DIVU: begin
            if (w_divZero)
               w_result = {r_hi, r_lo};
            else
               w_result = {w_remU, w_quotU};
         end
         default: w_result = {r_hi, r_lo};
      endcase
   end

   // Commands are only accepted in IDLE; anything arriving during RUN is dropped
   // and upstream is expected to hold it via stall_req.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_shHi  <= '0;
         r_shLo  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  case (w_op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_shHi  <= w_result[63:32];
                        r_shLo  <= w_result[31:0];
                        r_cnt   <= w_latency;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                     end
                     OP_MTHI: r_hi <= A;
                     OP_MTLO: r_lo <= A;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_hi    <= r_shHi;
                  r_lo    <= r_shLo;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign stall_req = r_busy | (start & w_isArith);

endmodule
